anim_sequencer: RTL and testbench

Multi-channel sprite animation sequencer. It replaces the single shared frame-pulse counter and the fixed 3-frame torpedo cycle with CHANNELS independent frame generators. Each channel has its own frame count, vsync divider and play mode, and outputs both a frame index and a ROM base address (frame*FRAME_SIZE). It sits beside the screen controller, clocked by clk_25, and feeds Draw_Sprite-based units such as torpedoes, ship and explosions.

---
 rtl/anim_pkg.sv | 30 +++
 rtl/anim_channel.sv | 110 +++++++++++
 rtl/anim_sequencer.sv | 50 +++++
 tb/tb_anim_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Shared types, widths and helpers for the sprite animation sequencer.
package anim_pkg;

    // Play mode per animation channel
    typedef enum logic [1:0] {
        AM_LOOP     = 2'd0,
        AM_ONESHOT  = 2'd1,
        AM_PINGPONG = 2'd2,
        AM_HOLD     = 2'd3
    } anim_mode_t;

    localparam int unsigned MAX_FRAMES = 8;
    localparam int unsigned MAX_DIV    = 16;
    localparam int unsigned FRAME_SIZE = 90;

    localparam int unsigned FW = $clog2(MAX_FRAMES);
    localparam int unsigned DW = $clog2(MAX_DIV + 1);
    localparam int unsigned AW = $clog2(FRAME_SIZE * MAX_FRAMES);

    // Index of the final frame; a count of 0 or 1 is a single still frame
    function automatic logic [FW-1:0] last_frame(input logic [FW-1:0] frames);
        return (frames <= FW'(1)) ? '0 : frames - FW'(1);
    endfunction

    // Divider reload value: effective divide ratio minus one, 0 behaves as 1
    function automatic logic [DW-1:0] div_reload(input logic [DW-1:0] div);
        return (div == '0) ? '0 : div - DW'(1);
    endfunction

endpackage

// File: rtl/anim_channel.sv
// One animation channel: vsync divider, frame stepping, busy/done and ROM base.
module anim_channel
    import anim_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic [FW-1:0] frames,
    input  logic [DW-1:0] div,
    input  anim_mode_t    mode,
    input  logic          start,
    output logic [FW-1:0] frame,
    output logic [AW-1:0] base,
    output logic          busy,
    output logic          done
);

    logic [DW-1:0] cnt;
    logic          going_down;

    logic [FW-1:0] last_c;
    logic [DW-1:0] reload_c;
    logic [FW:0]   frame_inc_c;
    logic [FW-1:0] next_frame_c;
    logic          next_down_c;
    logic          finish_c;

    assign last_c      = last_frame(frames);
    assign reload_c    = div_reload(div);
    assign frame_inc_c = (FW+1)'(frame) + (FW+1)'(1);

    // Frame and direction that a divider step would produce in the current mode
    always_comb begin
        next_frame_c = frame;
        next_down_c  = going_down;
        finish_c     = 1'b0;
        case (mode)
            AM_LOOP: begin
                next_frame_c = (frame >= last_c) ? '0 : frame + FW'(1);
            end
            AM_ONESHOT: begin
                if (busy) begin
                    if ((last_c == '0) || (frame_inc_c >= (FW+1)'(last_c))) begin
                        next_frame_c = last_c;
                        finish_c     = 1'b1;
                    end else begin
                        next_frame_c = frame + FW'(1);
                    end
                end
            end
            AM_PINGPONG: begin
                if (!going_down) begin
                    if (frame >= last_c) begin
                        next_down_c  = 1'b1;
                        next_frame_c = (last_c == '0) ? '0 : last_c - FW'(1);
                    end else begin
                        next_frame_c = frame + FW'(1);
                    end
                end else begin
                    if (frame == '0) begin
                        next_down_c  = 1'b0;
                        next_frame_c = (last_c == '0) ? '0 : FW'(1);
                    end else begin
                        next_frame_c = frame - FW'(1);
                    end
                end
            end
            default: begin
                next_frame_c = frame;
            end
        endcase
    end

    // Divider, frame state, oneshot handshake and registered ROM base address
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            frame      <= '0;
            going_down <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            base       <= '0;
        end else begin
            done <= 1'b0;
            base <= AW'(frame) * AW'(FRAME_SIZE);
            if (mode != AM_ONESHOT) begin
                busy <= 1'b0;
            end
            if (start) begin
                frame      <= '0;
                going_down <= 1'b0;
                cnt        <= reload_c;
                busy       <= (mode == AM_ONESHOT);
            end else if (tick) begin
                if (cnt == '0) begin
                    cnt        <= reload_c;
                    frame      <= next_frame_c;
                    going_down <= next_down_c;
                    if (finish_c) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// Multi-channel sprite animation sequencer: shared vsync tick, independent channels.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int unsigned CHANNELS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vsync,
    input  logic [CHANNELS-1:0][FW-1:0]  frames,
    input  logic [CHANNELS-1:0][DW-1:0]  div,
    input  logic [CHANNELS-1:0][1:0]     mode,
    input  logic [CHANNELS-1:0]          start,
    output logic                         tick,
    output logic [CHANNELS-1:0][FW-1:0]  frame,
    output logic [CHANNELS-1:0][AW-1:0]  base,
    output logic [CHANNELS-1:0]          busy,
    output logic [CHANNELS-1:0]          done
);

    logic vs_d;

    // Rising-edge detect on the raw vsync level
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_d <= 1'b0;
            tick <= 1'b0;
        end else begin
            vs_d <= vsync;
            tick <= vsync & ~vs_d;
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        anim_channel u_ch (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .frames (frames[g]),
            .div    (div[g]),
            .mode   (anim_mode_t'(mode[g])),
            .start  (start[g]),
            .frame  (frame[g]),
            .base   (base[g]),
            .busy   (busy[g]),
            .done   (done[g])
        );
    end

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_anim_sequencer;
    import anim_pkg::*;

    localparam int unsigned CH = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   vsync;
    logic [CH-1:0][FW-1:0]  frames;
    logic [CH-1:0][DW-1:0]  div;
    logic [CH-1:0][1:0]     mode;
    logic [CH-1:0]          start;
    logic                   tick;
    logic [CH-1:0][FW-1:0]  frame;
    logic [CH-1:0][AW-1:0]  base;
    logic [CH-1:0]          busy;
    logic [CH-1:0]          done;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int m_vs_d, m_tick;
    int m_frame[CH], m_base[CH], m_busy[CH], m_done[CH], m_cnt[CH], m_down[CH];
    int done_seen[CH];

    always #5 clk = ~clk;

    anim_sequencer #(.CHANNELS(CH)) dut (
        .clk    (clk),
        .reset  (reset),
        .vsync  (vsync),
        .frames (frames),
        .div    (div),
        .mode   (mode),
        .start  (start),
        .tick   (tick),
        .frame  (frame),
        .base   (base),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vs_d = 0;
        m_tick = 0;
        for (int c = 0; c < CH; c++) begin
            m_frame[c] = 0; m_base[c] = 0; m_busy[c] = 0;
            m_done[c]  = 0; m_cnt[c]  = 0; m_down[c] = 0;
        end
    endtask

    // One animation step of channel c, following the play-mode rules
    task automatic apply_step(input int c, input int last);
        case (mode[c])
            AM_LOOP:     m_frame[c] = (m_frame[c] >= last) ? 0 : m_frame[c] + 1;
            AM_ONESHOT:  if (m_busy[c] != 0) begin
                             if (last == 0 || m_frame[c] + 1 >= last) begin
                                 m_frame[c] = last; m_busy[c] = 0; m_done[c] = 1;
                             end else begin
                                 m_frame[c] = m_frame[c] + 1;
                             end
                         end
            AM_PINGPONG: if (m_down[c] == 0) begin
                             if (m_frame[c] >= last) begin
                                 m_down[c] = 1; m_frame[c] = (last == 0) ? 0 : last - 1;
                             end else begin
                                 m_frame[c] = m_frame[c] + 1;
                             end
                         end else begin
                             if (m_frame[c] == 0) begin
                                 m_down[c] = 0; m_frame[c] = (last < 1) ? last : 1;
                             end else begin
                                 m_frame[c] = m_frame[c] - 1;
                             end
                         end
            default: ;
        endcase
    endtask

    // Advance the model by one clock using the inputs presented this cycle
    task automatic model_clock();
        int last, deff;
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            last = (frames[c] <= 1) ? 0 : int'(frames[c]) - 1;
            deff = (div[c] == 0) ? 1 : int'(div[c]);
            m_base[c] = m_frame[c] * int'(FRAME_SIZE);
            m_done[c] = 0;
            if (mode[c] != AM_ONESHOT) m_busy[c] = 0;
            if (start[c]) begin
                m_frame[c] = 0; m_down[c] = 0; m_cnt[c] = deff - 1;
                m_busy[c] = (mode[c] == AM_ONESHOT) ? 1 : 0;
            end else if (m_tick != 0) begin
                if (m_cnt[c] == 0) begin
                    m_cnt[c] = deff - 1;
                    apply_step(c, last);
                end else begin
                    m_cnt[c] = m_cnt[c] - 1;
                end
            end
        end
        m_tick = (vsync && m_vs_d == 0) ? 1 : 0;
        m_vs_d = vsync ? 1 : 0;
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
        check("tick", 32'(tick), 32'(m_tick));
        for (int c = 0; c < CH; c++) begin
            check($sformatf("frame%0d", c), 32'(frame[c]), 32'(m_frame[c]));
            check($sformatf("base%0d", c),  32'(base[c]),  32'(m_base[c]));
            check($sformatf("busy%0d", c),  32'(busy[c]),  32'(m_busy[c]));
            check($sformatf("done%0d", c),  32'(done[c]),  32'(m_done[c]));
            if (done[c] === 1'b1) done_seen[c]++;
        end
    endtask

    task automatic vs_edge();
        vsync = 1'b1; cycle(); cycle();
        vsync = 1'b0; cycle(); cycle();
    endtask

    task automatic pulse_start(input int c);
        start[c] = 1'b1; cycle();
        start[c] = 1'b0;
    endtask

    task automatic set_ch(input int c, input int md, input int fr, input int dv);
        mode[c]   = 2'(md);
        frames[c] = FW'(fr);
        div[c]    = DW'(dv);
    endtask

    initial begin
        int pp_exp[8];
        int exp_f;
        pp_exp = '{1, 2, 1, 0, 1, 2, 1, 0};
        for (int c = 0; c < CH; c++) done_seen[c] = 0;
        model_reset();
        reset = 1'b1; vsync = 1'b0; start = '0;
        for (int c = 0; c < CH; c++) set_ch(c, AM_HOLD, 0, 0);
        cycle(); cycle();
        check("rst_tick", 32'(tick), 0);
        for (int c = 0; c < CH; c++) begin
            check("rst_frame", 32'(frame[c]), 0);
            check("rst_base",  32'(base[c]),  0);
            check("rst_busy",  32'(busy[c]),  0);
        end
        reset = 1'b0;

        // LOOP, 3 frames, divide by 12: steps on edges 1, 13, 25, 37
        set_ch(0, AM_LOOP, 3, 12);
        for (int n = 1; n <= 40; n++) begin
            vs_edge();
            exp_f = (1 + (n - 1) / 12) % 3;
            check("loop_frame", 32'(frame[0]), 32'(exp_f));
            check("loop_base",  32'(base[0]),  32'(exp_f * 90));
        end

        // ONESHOT, 4 frames, divide by 1
        set_ch(1, AM_ONESHOT, 4, 1);
        pulse_start(1);
        check("os_busy0", 32'(busy[1]), 1);
        check("os_frame0", 32'(frame[1]), 0);
        done_seen[1] = 0;
        for (int n = 1; n <= 3; n++) begin
            vs_edge();
            check("os_frame", 32'(frame[1]), 32'(n));
            check("os_busy",  32'(busy[1]),  (n < 3) ? 1 : 0);
        end
        check("os_done_cnt", 32'(done_seen[1]), 1);
        vs_edge(); vs_edge();
        check("os_hold_frame", 32'(frame[1]), 3);
        check("os_done_once", 32'(done_seen[1]), 1);

        // PINGPONG, 3 frames, divide by 1
        set_ch(2, AM_PINGPONG, 3, 1);
        pulse_start(2);
        for (int n = 0; n < 8; n++) begin
            vs_edge();
            check("pp_frame", 32'(frame[2]), 32'(pp_exp[n]));
        end

        // Degenerate LOOP and single-frame ONESHOT
        set_ch(3, AM_LOOP, 0, 0);
        for (int n = 0; n < 3; n++) begin
            vs_edge();
            check("deg_loop_frame", 32'(frame[3]), 0);
        end
        set_ch(3, AM_ONESHOT, 1, 0);
        done_seen[3] = 0;
        pulse_start(3);
        check("os1_busy", 32'(busy[3]), 1);
        vs_edge();
        check("os1_done", 32'(done_seen[3]), 1);
        check("os1_busy_end", 32'(busy[3]), 0);
        check("os1_frame", 32'(frame[3]), 0);

        // Start landing on the same cycle as a tick while busy at frame 2
        set_ch(1, AM_ONESHOT, 4, 3);
        pulse_start(1);
        for (int n = 0; n < 6; n++) vs_edge();
        check("co_pre_frame", 32'(frame[1]), 2);
        check("co_pre_busy", 32'(busy[1]), 1);
        done_seen[1] = 0;
        vsync = 1'b1; cycle();
        check("co_tick", 32'(tick), 1);
        start[1] = 1'b1; cycle(); start[1] = 1'b0;
        check("co_frame", 32'(frame[1]), 0);
        check("co_busy", 32'(busy[1]), 1);
        vsync = 1'b0; cycle(); cycle();
        check("co_no_done", 32'(done_seen[1]), 0);
        vs_edge(); vs_edge();
        check("co_reload_frame", 32'(frame[1]), 0);
        vs_edge();
        check("co_step_frame", 32'(frame[1]), 1);

        // Reset in the middle of activity
        vsync = 1'b1; cycle();
        reset = 1'b1; cycle();
        check("mid_rst_tick", 32'(tick), 0);
        for (int c = 0; c < CH; c++) begin
            check("mid_rst_frame", 32'(frame[c]), 0);
            check("mid_rst_base",  32'(base[c]),  0);
            check("mid_rst_busy",  32'(busy[c]),  0);
            check("mid_rst_done",  32'(done[c]),  0);
        end
        reset = 1'b0; vsync = 1'b0; cycle();

        // All channels together with distinct settings
        set_ch(0, AM_LOOP, 5, 2);
        set_ch(1, AM_ONESHOT, 6, 1);
        set_ch(2, AM_PINGPONG, 4, 3);
        set_ch(3, AM_LOOP, 7, 0);
        start = '1; cycle(); start = '0;
        for (int n = 0; n < 30; n++) vs_edge();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) begin
                for (int c = 0; c < CH; c++)
                    set_ch(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 16)));
            end
            if ($urandom_range(0, 2) == 0) vsync = ~vsync;
            for (int c = 0; c < CH; c++) start[c] = ($urandom_range(0, 40) == 0);
            reset = ($urandom_range(0, 400) == 0);
            cycle();
        end
        reset = 1'b0; start = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
